// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, legal byte-mask
// patterns, error codes and the mask/offset alignment rule.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_B1 = 4'b0010;
   localparam logic [3:0] MASK_B2 = 4'b0100;
   localparam logic [3:0] MASK_B3 = 4'b1000;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;

   // A mask is legal only when its lowest enabled lane sits at the byte offset.
   function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      case (mask)
         MASK_B0: ok = (off == 2'd0);
         MASK_B1: ok = (off == 2'd1);
         MASK_B2: ok = (off == 2'd2);
         MASK_B3: ok = (off == 2'd3);
         MASK_H0: ok = (off == 2'd0);
         MASK_H1: ok = (off == 2'd2);
         MASK_W:  ok = (off == 2'd0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enable write, synchronous read.
// Contents are deliberately not reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    be,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // The read register holds its value while idle, so it stays stable in RESP.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding load/store, fixed wait latency, then a
// held response with error flag. Owns the FSM, wait counter and access checks.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_wen,
   input  logic [31:0]       i_wdata,
   input  logic [3:0]        i_mask,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       o_rdata,
   output logic              o_err,
   output state_t            o_dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   // Handshakes: a request transfers on a rising edge where i_req_valid and
   // o_req_ready are both high; a response transfers on a rising edge where
   // o_rsp_valid and i_rsp_ready are both high. Valid data is held until taken.

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [31:0]       wdata_q;
   logic [3:0]        mask_q;
   logic [1:0]        err_q;
   logic              load_q;

   logic              accept;
   logic              exec;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_wen;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_mask;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        acc_err;
   logic [31:0]       mem_rdata;

   assign o_req_ready = (state_q == ST_IDLE) & ~i_rst;
   assign accept      = i_req_valid & o_req_ready;

   // With zero latency the access happens on the accept edge, straight from the inputs.
   assign acc_addr  = (state_q == ST_IDLE) ? i_addr  : addr_q;
   assign acc_wen   = (state_q == ST_IDLE) ? i_wen   : wen_q;
   assign acc_wdata = (state_q == ST_IDLE) ? i_wdata : wdata_q;
   assign acc_mask  = (state_q == ST_IDLE) ? i_mask  : mask_q;
   assign word_idx  = {2'b00, acc_addr[ADDR_W-1:2]};

   always_comb begin
      acc_err = ERR_NONE;
      if (!mask_legal(acc_mask, acc_addr[1:0])) begin
         acc_err = ERR_MISALIGN;
      end else if (word_idx >= ADDR_W'(DEPTH_WORDS)) begin
         acc_err = ERR_RANGE;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exec    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  exec    = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd0) begin
               exec    = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (i_rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= 32'd0;
         mask_q  <= 4'd0;
         err_q   <= ERR_NONE;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= i_addr;
            wen_q   <= i_wen;
            wdata_q <= i_wdata;
            mask_q  <= i_mask;
         end
         if (exec) begin
            err_q  <= acc_err;
            load_q <= ~acc_wen;
         end
      end
   end

   // Rejected accesses never enable the array, so they cannot write.
   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk  (i_clk),
      .en   (exec & (acc_err == ERR_NONE)),
      .we   (acc_wen),
      .addr (acc_addr[AW+1:2]),
      .wdata(acc_wdata),
      .be   (acc_mask),
      .rdata(mem_rdata)
   );

   assign o_rsp_valid = (state_q == ST_RESP);
   assign o_err       = o_rsp_valid & (err_q != ERR_NONE);
   assign o_rdata     = (o_rsp_valid && load_q && err_q == ERR_NONE) ? mem_rdata : 32'd0;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: word-array reference model, response scoreboard
// with per-cycle compare process, and literal checks on key results.
module tb_dmem_resp;
   import dmem_pkg::*;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [31:0] i_addr = 32'd0;
   logic        i_wen = 1'b0;
   logic [31:0] i_wdata = 32'd0;
   logic [3:0]  i_mask = 4'd0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b1;
   logic [31:0] o_rdata;
   logic        o_err;
   state_t      o_dbg_state;

   dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_req_valid(i_req_valid),
      .o_req_ready(o_req_ready),
      .i_addr     (i_addr),
      .i_wen      (i_wen),
      .i_wdata    (i_wdata),
      .i_mask     (i_mask),
      .o_rsp_valid(o_rsp_valid),
      .i_rsp_ready(i_rsp_ready),
      .o_rdata    (o_rdata),
      .o_err      (o_err),
      .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] model_mem [DEPTH];
   logic [32:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Legal = 1/2/4 contiguous lanes starting at the byte offset, naturally aligned.
   function automatic bit model_legal(input logic [31:0] addr, input logic [3:0] mask);
      int n, lo, off;
      logic [3:0] shape;
      n   = $countones(mask);
      lo  = 0;
      off = int'(addr[1:0]);
      for (int i = 3; i >= 0; i--) if (mask[i]) lo = i;
      if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
      shape = 4'(((1 << n) - 1) << lo);
      if (shape != mask) return 1'b0;
      if (lo != off) return 1'b0;
      if ((off % n) != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Compare process: every response cycle is checked against the scoreboard head.
   logic        prev_valid = 1'b0;
   logic [32:0] cur = 33'd0;
   always @(negedge clk) begin
      if (i_rst) begin
         check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
         check("rst_req_ready", 32'(o_req_ready), 32'd0);
         check("rst_rdata", o_rdata, 32'd0);
         check("rst_err", 32'(o_err), 32'd0);
         prev_valid = 1'b0;
      end else begin
         if (o_rsp_valid) begin
            if (!prev_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_rsp: got rdata %h err %b, required no response", o_rdata, o_err);
                  cur = {o_err, o_rdata};
               end else begin
                  cur = exp_q.pop_front();
               end
            end
            check("rsp_rdata", o_rdata, cur[31:0]);
            check("rsp_err", 32'(o_err), 32'(cur[32]));
            check("rsp_req_ready", 32'(o_req_ready), 32'd0);
         end
         prev_valid = o_rsp_valid;
      end
   end

   task automatic access(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                         input logic [3:0] mask, input int hold,
                         output logic [31:0] got_rd, output logic got_err);
      bit ok;
      int t, lat;
      logic [31:0] exp_rd;
      ok = model_legal(addr, mask) && ((addr >> 2) < DEPTH);
      exp_rd = (ok && !wen) ? model_mem[addr[11:2]] : 32'd0;
      exp_q.push_back({~ok, exp_rd});
      if (ok && wen) begin
         for (int i = 0; i < 4; i++) if (mask[i]) model_mem[addr[11:2]][8*i +: 8] = wd[8*i +: 8];
      end
      @(negedge clk);
      i_addr = addr; i_wen = wen; i_wdata = wd; i_mask = mask;
      i_req_valid = 1'b1;
      i_rsp_ready = (hold == 0);
      t = 0;
      while (!o_req_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin n_cmp++; n_bad++; $display("FAIL req_timeout: got no ready, required ready within 50 cycles"); end
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      lat = 1;
      while (!o_rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      check("latency", 32'(lat), 32'(LAT + 1));
      got_rd  = o_rdata;
      got_err = o_err;
      for (int k = 0; k < hold; k++) begin
         i_req_valid = 1'b1;
         i_addr = addr ^ 32'h100;
         i_wen = ~wen;
         @(negedge clk);
         check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rsp_dropped", 32'(o_rsp_valid), 32'd0);
      check("ready_again", 32'(o_req_ready), 32'd1);
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      #1 i_rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));
      #2 i_rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready", 32'(o_req_ready), 32'd1);

      // full word store then load
      access(32'h40, 1'b1, 32'h12345678, 4'b1111, 0, rd, er);
      check("store_rdata_zero", rd, 32'd0);
      access(32'h40, 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("load_word", rd, 32'h12345678);
      check("load_word_err", 32'(er), 32'd0);

      // byte lane 1 merge
      access(32'h41, 1'b1, 32'h0000AB00, 4'b0010, 0, rd, er);
      access(32'h40, 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("byte_merge", rd, 32'h1234AB78);

      // misaligned requests must not write
      access(32'h42, 1'b1, 32'hFFFFFFFF, 4'b1111, 0, rd, er);
      check("misalign_word_err", 32'(er), 32'd1);
      access(32'h43, 1'b1, 32'hFFFFFFFF, 4'b0011, 0, rd, er);
      check("misalign_half_err", 32'(er), 32'd1);
      access(32'h40, 1'b0, 32'h0, 4'b0000, 0, rd, er);
      check("mask_zero_err", 32'(er), 32'd1);
      check("mask_zero_rdata", rd, 32'd0);
      access(32'h40, 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("unchanged_after_err", rd, 32'h1234AB78);

      // upper half and top byte lanes
      access(32'h42, 1'b1, 32'hBEEF0000, 4'b1100, 0, rd, er);
      access(32'h43, 1'b1, 32'h5A000000, 4'b1000, 0, rd, er);
      access(32'h40, 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("upper_lanes", rd, 32'h5AEFAB78);

      // range boundary: last word legal, first word past the end rejected
      access(32'(DEPTH * 4 - 4), 1'b1, 32'hA5A5C3C3, 4'b1111, 0, rd, er);
      access(32'(DEPTH * 4 - 4), 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("last_word", rd, 32'hA5A5C3C3);
      access(32'(DEPTH * 4), 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("oob_err", 32'(er), 32'd1);
      check("oob_rdata", rd, 32'd0);

      // backpressure: response held 5 cycles while a stray request is offered
      access(32'h40, 1'b0, 32'h0, 4'b1111, 5, rd, er);
      check("bp_rdata", rd, 32'h5AEFAB78);
      repeat (4) @(negedge clk);

      // reset while a store is waiting in BUSY
      access(32'h10, 1'b1, 32'h11111111, 4'b1111, 0, rd, er);
      @(negedge clk);
      i_addr = 32'h10; i_wen = 1'b1; i_wdata = 32'hDEADBEEF; i_mask = 4'b1111;
      i_req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      check("busy_before_rst", 32'(o_dbg_state), 32'(ST_BUSY));
      #2 i_rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 i_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
      end
      access(32'h10, 1'b0, 32'h0, 4'b1111, 0, rd, er);
      check("rst_no_partial_write", rd, 32'h11111111);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
